// File: rtl/multiexp_pnt_scl_feeder_pkg.sv
// Shared multiexp definitions: field-element widths, point word count,
// stream mode encodings and the feeder FSM state type.
package multiexp_pnt_scl_feeder_pkg;

    // One Fp field element is one memory word / stream beat.
    localparam int FE_BITS    = 381;
    // An Fp2 element is two field elements; a Jacobian point has three coordinates.
    localparam int FP2_WRDS   = 2;
    localparam int JAC_COORDS = 3;
    localparam int PNT_WRDS   = FP2_WRDS * JAC_COORDS;

    // Stream ctl bit that selects the single-add (collapse) reduction path.
    localparam int CTL_SINGLE_ADD = 0;

    typedef logic [FE_BITS-1:0] fe_t;

    typedef struct packed {
        fe_t c1;
        fe_t c0;
    } fp2_t;

    typedef enum logic {
        MODE_MULTIEXP = 1'b0,
        MODE_COLLAPSE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Memory words occupied by one input item: scalar + point, or point only.
    function automatic int unsigned item_wrds(input mode_e mode, input int unsigned num_wrds);
        return (mode == MODE_COLLAPSE) ? num_wrds : num_wrds + 1;
    endfunction

endpackage

// File: rtl/multiexp_pnt_scl_feeder_if.sv
// AXI-style stream carrying scalar/point beats into the multiexp core.
interface multiexp_pnt_scl_feeder_if
    import multiexp_pnt_scl_feeder_pkg::*;
#(
    parameter int DAT_BITS = FE_BITS,
    parameter int CTL_BITS = 16
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;

    modport source (output val, sop, eop, dat, ctl, input rdy);
    modport sink   (input val, sop, eop, dat, ctl, output rdy);
    modport master (output val, sop, eop, dat, ctl, input rdy);
    modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_pnt_scl_feeder_fifo.sv
// First-word-fall-through output buffer with an occupancy count, used
// by the feeder to absorb read latency and downstream backpressure.
module multiexp_pnt_scl_feeder_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [WIDTH-1:0]    i_wr_dat,
    input  logic                i_rd_en,
    output logic [WIDTH-1:0]    o_rd_dat,
    output logic [CNT_BITS-1:0] o_count
);
    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic                do_pop;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] ptr);
        return (ptr == PTR_BITS'(DEPTH - 1)) ? '0 : ptr + PTR_BITS'(1);
    endfunction

    assign do_pop   = i_rd_en && (count_q != '0);
    assign o_rd_dat = mem_q[rd_ptr_q];
    assign o_count  = count_q;

    // Storage write port.
    // NOTE: the data array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem_q[wr_ptr_q] <= i_wr_dat;
    end

    // Pointer and occupancy bookkeeping; the caller guarantees no write when full.
    // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({i_wr_en, do_pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/multiexp_pnt_scl_feeder.sv
// Source end of the multiexp scalar/point stream. Reads scalar/point pairs
// from word-wide memory and replays them once per key bit (MSB first), with
// the scalar pre-shifted so the bit under test sits at KEY_BITS-1. Collapse
// mode streams raw points once with ctl[0]=1.
module multiexp_pnt_scl_feeder
    import multiexp_pnt_scl_feeder_pkg::*;
#(
    parameter int DAT_BITS   = FE_BITS,
    parameter int NUM_WRDS   = PNT_WRDS,
    parameter int KEY_BITS   = 256,
    parameter int CTL_BITS   = 16,
    parameter int ADR_BITS   = 20,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_mode,
    input  logic [63:0]               i_num_in,
    input  logic [ADR_BITS-1:0]       i_base_addr,
    output logic                      o_rd_en,
    output logic [ADR_BITS-1:0]       o_rd_addr,
    input  logic [DAT_BITS-1:0]       i_rd_dat,
    multiexp_pnt_scl_feeder_if.source o_pnt_scl_if,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int WRD_BITS = $clog2(NUM_WRDS + 2);
    localparam int SH_BITS  = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);

    // Side information travelling alongside each outstanding read.
    typedef struct packed {
        logic               vld;
        logic               is_scalar;
        logic               sop;
        logic               eop;
        logic [SH_BITS-1:0] shamt;
    } rd_tag_t;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic [63:0]           num_in_q;
    logic [63:0]           in_cnt_q;
    logic [63:0]           pass_cnt_q;
    logic [ADR_BITS-1:0]   base_q;
    logic [ADR_BITS-1:0]   off_q;
    logic [WRD_BITS-1:0]   wrd_cnt_q;
    logic [WRD_BITS-1:0]   wrd_last;
    rd_tag_t               tag_pipe_q [RD_LAT];
    rd_tag_t               issue_tag;
    logic [CNT_BITS-1:0]   inflight_q;
    logic [CNT_BITS-1:0]   fifo_count;
    logic                  last_wrd, last_in, last_pass, last_read;
    logic                  credit_ok, accept_start;
    logic                  wr_en, pop, out_val;
    logic [DAT_BITS-1:0]   key_mask, wr_dat;
    logic [DAT_BITS+1:0]   fifo_dat;

    assign accept_start = (state_q == ST_IDLE) && i_start;
    assign o_rd_en      = (state_q == ST_RUN) && credit_ok;
    assign o_rd_addr    = base_q + off_q;

    // Iteration end flags, read credit and the tag for a read issued this cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wrd_last  = WRD_BITS'(item_wrds(mode_q, NUM_WRDS) - 1);
        last_wrd  = (wrd_cnt_q == wrd_last);
        last_in   = (in_cnt_q == num_in_q - 64'd1);
        last_pass = (mode_q == MODE_COLLAPSE) || (pass_cnt_q == 64'(KEY_BITS - 1));
        last_read = last_wrd && last_in && last_pass;
        credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_BITS + 1)'(FIFO_DEPTH);
        issue_tag           = '0;
        issue_tag.vld       = o_rd_en;
        issue_tag.is_scalar = (mode_q == MODE_MULTIEXP) && (wrd_cnt_q == '0);
        issue_tag.sop       = (wrd_cnt_q == '0);
        issue_tag.eop       = last_wrd;
        issue_tag.shamt     = pass_cnt_q[SH_BITS-1:0];
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) state_d = (i_num_in == 64'd0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (o_rd_en && last_read) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                // Finish on the cycle the last buffered beat leaves.
                if (inflight_q == '0 &&
                    (fifo_count == '0 || (fifo_count == CNT_BITS'(1) && pop)))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Job configuration and word/item/pass iteration counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q     <= MODE_MULTIEXP;
            num_in_q   <= '0;
            base_q     <= '0;
            off_q      <= '0;
            wrd_cnt_q  <= '0;
            in_cnt_q   <= '0;
            pass_cnt_q <= '0;
        end else if (accept_start) begin
            mode_q     <= mode_e'(i_mode);
            num_in_q   <= i_num_in;
            base_q     <= i_base_addr;
            off_q      <= '0;
            wrd_cnt_q  <= '0;
            in_cnt_q   <= '0;
            pass_cnt_q <= '0;
        end else if (o_rd_en) begin
            if (!last_wrd) begin
                wrd_cnt_q <= wrd_cnt_q + WRD_BITS'(1);
                off_q     <= off_q + ADR_BITS'(1);
            end else begin
                wrd_cnt_q <= '0;
                if (!last_in) begin
                    in_cnt_q <= in_cnt_q + 64'd1;
                    off_q    <= off_q + ADR_BITS'(1);
                end else begin
                    // Each pass replays the same items from the base address.
                    in_cnt_q <= '0;
                    off_q    <= '0;
                    if (!last_pass) pass_cnt_q <= pass_cnt_q + 64'd1;
                end
            end
        end
    end

    // Read-latency tag pipeline and count of reads whose data has not yet landed.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe_q[i] <= '0;
            inflight_q <= '0;
        end else begin
            tag_pipe_q[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
            case ({o_rd_en, wr_en})
                2'b10:   inflight_q <= inflight_q + CNT_BITS'(1);
                2'b01:   inflight_q <= inflight_q - CNT_BITS'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Returning word: scalars are shifted and trimmed to KEY_BITS on the way into the buffer.
    always_comb begin
        key_mask = '0;
        for (int i = 0; i < DAT_BITS; i++) begin
            if (i < KEY_BITS) key_mask[i] = 1'b1;
        end
        wr_en  = tag_pipe_q[RD_LAT-1].vld;
        wr_dat = i_rd_dat;
        if (tag_pipe_q[RD_LAT-1].is_scalar)
            wr_dat = (i_rd_dat << tag_pipe_q[RD_LAT-1].shamt) & key_mask;
    end

    multiexp_pnt_scl_feeder_fifo #(
        .WIDTH    (DAT_BITS + 2),
        .DEPTH    (FIFO_DEPTH),
        .CNT_BITS (CNT_BITS)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (wr_en),
        .i_wr_dat ({tag_pipe_q[RD_LAT-1].sop, tag_pipe_q[RD_LAT-1].eop, wr_dat}),
        .i_rd_en  (pop),
        .o_rd_dat (fifo_dat),
        .o_count  (fifo_count)
    );

    assign out_val = (fifo_count != '0);
    assign pop     = out_val && o_pnt_scl_if.rdy;

    assign o_pnt_scl_if.val = out_val;
    assign o_pnt_scl_if.sop = out_val && fifo_dat[DAT_BITS+1];
    assign o_pnt_scl_if.eop = out_val && fifo_dat[DAT_BITS];
    assign o_pnt_scl_if.dat = out_val ? fifo_dat[DAT_BITS-1:0] : '0;
    assign o_pnt_scl_if.ctl = out_val ? (CTL_BITS'(mode_q) << CTL_SINGLE_ADD) : '0;

endmodule

// File: tb/tb_multiexp_pnt_scl_feeder.sv
// Directed bench for the scalar/point feeder: a memory model with fixed read
// latency, a beat scoreboard and a read-address scoreboard filled from a
// reference model of the pass/item/word iteration.
module tb_multiexp_pnt_scl_feeder;
    import multiexp_pnt_scl_feeder_pkg::*;

    localparam int DAT_BITS   = 64;
    localparam int NUM_WRDS   = 6;
    localparam int KEY_BITS   = 4;
    localparam int CTL_BITS   = 16;
    localparam int ADR_BITS   = 8;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int MEM_WRDS   = 1 << ADR_BITS;
    localparam logic [DAT_BITS-1:0] KEY_MASK = (64'd1 << KEY_BITS) - 64'd1;

    typedef struct packed {
        logic [DAT_BITS-1:0] dat;
        logic                sop;
        logic                eop;
        logic [CTL_BITS-1:0] ctl;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic [63:0]         num_in = '0;
    logic [ADR_BITS-1:0] base_addr = '0;
    logic                rd_en;
    logic [ADR_BITS-1:0] rd_addr;
    logic [DAT_BITS-1:0] rd_dat;
    logic                busy;
    logic                done;
    logic                rdy = 1'b1;
    logic                rand_rdy = 1'b0;

    logic [DAT_BITS-1:0] mem [MEM_WRDS];
    logic [ADR_BITS-1:0] pipe_addr [RD_LAT];
    logic [RD_LAT-1:0]   pipe_vld = '0;

    beat_t               exp_q [$];
    logic [ADR_BITS-1:0] addr_q [$];
    int                  n_tests = 0;
    int                  n_fail = 0;
    int                  beats_seen = 0;
    int                  reads_seen = 0;
    int                  done_seen = 0;
    int                  outstanding = 0;
    beat_t               prev_beat;
    logic                prev_stall = 1'b0;

    multiexp_pnt_scl_feeder_if #(.DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS)) pnt_scl_if ();
    assign pnt_scl_if.rdy = rdy;

    multiexp_pnt_scl_feeder #(
        .DAT_BITS   (DAT_BITS),
        .NUM_WRDS   (NUM_WRDS),
        .KEY_BITS   (KEY_BITS),
        .CTL_BITS   (CTL_BITS),
        .ADR_BITS   (ADR_BITS),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_mode       (mode),
        .i_num_in     (num_in),
        .i_base_addr  (base_addr),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .i_rd_dat     (rd_dat),
        .o_pnt_scl_if (pnt_scl_if),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Memory model: data for a read appears RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        pipe_vld[0]  <= rd_en;
        pipe_addr[0] <= rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
    end
    assign rd_dat = pipe_vld[RD_LAT-1] ? mem[pipe_addr[RD_LAT-1]] : 64'hBAD0_BAD0_BAD0_BAD0;

    // Sink readiness: always ready, or ready 70% of cycles.
    always @(posedge clk) begin
        #1;
        rdy = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected read addresses and beats for one job.
    task automatic push_job(input logic m, input int num, input logic [ADR_BITS-1:0] base);
        int                  passes;
        int                  wrds;
        logic [ADR_BITS-1:0] a;
        beat_t               b;
        passes = m ? 1 : KEY_BITS;
        wrds   = m ? NUM_WRDS : NUM_WRDS + 1;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < num; k++) begin
                for (int w = 0; w < wrds; w++) begin
                    a = base + ADR_BITS'(k * wrds + w);
                    addr_q.push_back(a);
                    b.dat = mem[a];
                    if (!m && w == 0) b.dat = (mem[a] << p) & KEY_MASK;
                    b.sop = (w == 0);
                    b.eop = (w == wrds - 1);
                    b.ctl = CTL_BITS'(m);
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Monitor: read addresses, read credit, beat contents and stall stability.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur.dat = pnt_scl_if.dat;
        cur.sop = pnt_scl_if.sop;
        cur.eop = pnt_scl_if.eop;
        cur.ctl = pnt_scl_if.ctl;
        if (rd_en) begin
            check("rd_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
            check("rd_credit", (outstanding + 1) <= FIFO_DEPTH, 1);
            reads_seen++;
            outstanding++;
        end
        if (prev_stall) check("hold", {pnt_scl_if.val, cur}, {1'b1, prev_beat});
        if (pnt_scl_if.val && rdy) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", cur, e);
            end
            beats_seen++;
            outstanding--;
        end
        if (done) done_seen++;
        prev_stall = pnt_scl_if.val && !rdy && !rst;
        prev_beat  = cur;
    end

    task automatic start_job(input logic m, input int num, input logic [ADR_BITS-1:0] base);
        mode      = m;
        num_in    = 64'(num);
        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nbeats, input int b0, input int d0);
        int cyc;
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_low"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_beats"}, beats_seen - b0, nbeats);
        check({tag, "_sb_empty"}, exp_q.size() + addr_q.size(), 0);
        check({tag, "_done_cnt"}, done_seen - d0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        int b0;
        int r0;
        int d0;

        for (int a = 0; a < MEM_WRDS; a++)
            mem[a] = {32'hC0DE_0000 | 32'(a), 32'(a) * 32'h9E37_79B1};
        // Scalars for the pair tests carry junk above the key bits.
        mem[8'h10] = 64'hFFFF_0000_0000_00FA;
        mem[8'h17] = 64'h1234_0000_0000_0003;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_val", pnt_scl_if.val, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: two pairs, four passes, sink always ready.
        push_job(1'b0, 2, 8'h10);
        b0 = beats_seen; d0 = done_seen;
        start_job(1'b0, 2, 8'h10);
        lat = 1;
        while (!pnt_scl_if.val && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t1_latency", lat, RD_LAT + 2);
        check("t1_busy", busy, 1);
        wait_done("t1", 56, b0, d0);

        // Test 2: collapse mode, three points.
        push_job(1'b1, 3, 8'h40);
        b0 = beats_seen; d0 = done_seen;
        start_job(1'b1, 3, 8'h40);
        wait_done("t2", 18, b0, d0);

        // Test 3: empty job.
        b0 = beats_seen; d0 = done_seen; r0 = reads_seen;
        start_job(1'b0, 0, 8'h10);
        check("t3_done_lat", done, 1);
        check("t3_busy", busy, 0);
        @(posedge clk); #1;
        check("t3_done_pulse", done, 0);
        repeat (10) @(posedge clk);
        #1;
        check("t3_reads", reads_seen - r0, 0);
        check("t3_beats", beats_seen - b0, 0);
        check("t3_done_cnt", done_seen - d0, 1);

        // Test 4: test 1 again under random backpressure.
        rand_rdy = 1'b1;
        push_job(1'b0, 2, 8'h10);
        b0 = beats_seen; d0 = done_seen;
        start_job(1'b0, 2, 8'h10);
        wait_done("t4", 56, b0, d0);
        rand_rdy = 1'b0;
        @(posedge clk); #1;

        // Test 5: reset during pass 2, then a clean rerun.
        push_job(1'b0, 2, 8'h10);
        b0 = beats_seen;
        start_job(1'b0, 2, 8'h10);
        cyc = 0;
        while ((beats_seen - b0) < 31 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t5_in_pass2", (beats_seen - b0) >= 31, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_val", pnt_scl_if.val, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_rd_en", rd_en, 0);
        exp_q.delete();
        addr_q.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        b0 = beats_seen; r0 = reads_seen;
        repeat (10) @(posedge clk);
        #1;
        check("t5_quiet_beats", beats_seen - b0, 0);
        check("t5_quiet_reads", reads_seen - r0, 0);
        push_job(1'b0, 2, 8'h10);
        b0 = beats_seen; d0 = done_seen;
        start_job(1'b0, 2, 8'h10);
        wait_done("t5", 56, b0, d0);

        // Test 6: address wrap near the top of memory; a start while busy is ignored.
        push_job(1'b1, 3, 8'd250);
        b0 = beats_seen; d0 = done_seen;
        start_job(1'b1, 3, 8'd250);
        repeat (3) @(posedge clk);
        #1;
        check("t6_busy", busy, 1);
        start_job(1'b0, 5, 8'h00);
        wait_done("t6", 18, b0, d0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
